// File: rtl/uart_pkg.sv
// uart_pkg: state encodings and default sizes shared by the UART blocks.
// Used by uart_rx today and by uart_tx later.
package uart_pkg;

   localparam int UART_NB_DATA      = 8;
   localparam int UART_OVERSAMPLING = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_state_e;

endpackage

// File: rtl/uart_sync_2ff.sv
// uart_sync_2ff: two-flop synchronizer for a single async input.
// RST_VAL sets the value both flops take while reset is high.
module uart_sync_2ff #(
   parameter bit RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic i_reset,
   input  logic i_d,
   output logic o_q
);

   logic meta;

   // two back-to-back flops to settle metastability
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         meta <= RST_VAL;
         o_q  <= RST_VAL;
      end else begin
         meta <= i_d;
         o_q  <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampled 8N1 UART receiver with framing error flag.
// Define UART_RX_PARITY_EN to add a parity bit and o_parity_err.
module uart_rx
   import uart_pkg::*;
#(
   parameter int NB_DATA      = UART_NB_DATA,
   parameter int OVERSAMPLING = UART_OVERSAMPLING,
   parameter bit PARITY_ODD   = 1'b0
) (
   input  logic               clk,
   input  logic               i_reset,
   input  logic               i_tick,
   input  logic               i_rx,
   output logic [NB_DATA-1:0] o_data,
   output logic               o_rx_done,
   output logic               o_frame_err,
   output logic               o_parity_err,
   output logic               o_busy
);

   localparam int SW = $clog2(OVERSAMPLING);
   localparam int NW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
   localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLING / 2 - 1);
   localparam logic [SW-1:0] S_END  = SW'(OVERSAMPLING - 1);
   localparam logic [NW-1:0] N_LAST = NW'(NB_DATA - 1);

   uart_state_e        state_q, state_d;
   logic [SW-1:0]      s_q, s_d;
   logic [NW-1:0]      n_q, n_d;
   logic [NB_DATA-1:0] sr_q, sr_d;
   logic [NB_DATA-1:0] data_q, data_d;
   logic               done_q, done_d;
   logic               ferr_q, ferr_d;
   logic               rx_s;

`ifdef UART_RX_PARITY_EN
   logic               par_q, par_d;
   logic               perr_q, perr_d;
`endif

   uart_sync_2ff #(
      .RST_VAL (1'b1)
   ) u_sync (
      .clk     (clk),
      .i_reset (i_reset),
      .i_d     (i_rx),
      .o_q     (rx_s)
   );

   // state, counters, shift register and registered outputs
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= ST_IDLE;
         s_q     <= '0;
         n_q     <= '0;
         sr_q    <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q   <= 1'b0;
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         n_q     <= n_d;
         sr_q    <= sr_d;
         data_q  <= data_d;
         done_q  <= done_d;
         ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
         par_q   <= par_d;
         perr_q  <= perr_d;
`endif
      end
   end

   // next state: counters only move on ticks, start detect does not need one
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      n_d     = n_q;
      sr_d    = sr_q;
      data_d  = data_q;
      done_d  = 1'b0;
      ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
      par_d   = par_q;
      perr_d  = perr_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (!rx_s) begin
               state_d = ST_START;
               s_d     = '0;
            end
         end
         ST_START: begin
            if (i_tick) begin
               if (s_q == S_MID) begin
                  s_d = '0;
                  if (rx_s) begin
                     state_d = ST_IDLE;
                  end else begin
                     state_d = ST_DATA;
                     n_d     = '0;
                  end
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end
         ST_DATA: begin
            if (i_tick) begin
               if (s_q == S_END) begin
                  s_d  = '0;
                  sr_d = {rx_s, sr_q[NB_DATA-1:1]};
                  if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state_d = ST_PARITY;
`else
                     state_d = ST_STOP;
`endif
                  end else begin
                     n_d = n_q + 1'b1;
                  end
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (i_tick) begin
               if (s_q == S_END) begin
                  s_d     = '0;
                  par_d   = rx_s;
                  state_d = ST_STOP;
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end
`endif
         ST_STOP: begin
            if (i_tick) begin
               if (s_q == S_END) begin
                  s_d     = '0;
                  data_d  = sr_q;
                  ferr_d  = ~rx_s;
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                  perr_d  = (^sr_q) ^ par_q ^ PARITY_ODD;
`endif
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign o_data      = data_q;
   assign o_rx_done   = done_q;
   assign o_frame_err = ferr_q;
   assign o_busy      = (state_q != ST_IDLE);

`ifdef UART_RX_PARITY_EN
   assign o_parity_err = perr_q;
`else
   // no parity bit in the frame, so the parity sense has no effect
   assign o_parity_err = PARITY_ODD & 1'b0;
`endif

endmodule
